// File: rtl/multichannel_rd_arbiter.sv
// Four-channel round-robin arbiter in front of a single AXI read master.
// Each grant issues one burst, waits for rd_done, then returns through IDLE.
module multichannel_rd_arbiter #(
   parameter int AXI_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [3:0]           rd_req,
   input  logic [29:0]          rd_addr0,
   input  logic [29:0]          rd_addr1,
   input  logic [29:0]          rd_addr2,
   input  logic [29:0]          rd_addr3,
   input  logic [7:0]           rd_len0,
   input  logic [7:0]           rd_len1,
   input  logic [7:0]           rd_len2,
   input  logic [7:0]           rd_len3,
   output logic [3:0]           rd_grant,
   input  logic                 rd_done,
   output logic                 axi_rd_start,
   output logic [29:0]          axi_rd_addr,
   output logic [7:0]           axi_rd_len,
   input  logic [AXI_WIDTH-1:0] axi_rd_data,
   input  logic                 axi_rd_data_valid,
   output logic [AXI_WIDTH-1:0] rd_data,
   output logic [3:0]           rd_data_valid
);

   typedef enum logic [4:0] {
      IDLE = 5'b00001,
      S0   = 5'b00010,
      S1   = 5'b00100,
      S2   = 5'b01000,
      S3   = 5'b10000
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [1:0]           r_ptr;
   logic [1:0]           w_ptr_nxt;
   logic                 r_issued;
   logic                 w_issued_nxt;
   logic [1:0]           w_pick;
   logic [1:0]           w_cand;
   logic [1:0]           w_cur;
   logic                 w_start;
   logic [29:0]          w_addr;
   logic [7:0]           w_len;
   logic [3:0]           w_grant;
   logic [AXI_WIDTH-1:0] r_rd_data;
   logic [3:0]           r_rd_data_valid;

   function automatic state_t grant_state(input logic [1:0] idx);
      state_t s;
      case (idx)
         2'd0:    s = S0;
         2'd1:    s = S1;
         2'd2:    s = S2;
         2'd3:    s = S3;
         default: s = IDLE;
      endcase
      return s;
   endfunction

   // Round-robin pick: scan backwards so the requester nearest ptr wins.
   always_comb begin
      w_pick = r_ptr;
      w_cand = r_ptr;
      for (int j = 3; j >= 0; j--) begin
         w_cand = r_ptr + 2'(j);
         if (rd_req[w_cand]) begin
            w_pick = w_cand;
         end else begin
            w_pick = w_pick;
         end
      end
   end

   // Channel index of the current grant state.
   always_comb begin
      case (r_state)
         S0:      w_cur = 2'd0;
         S1:      w_cur = 2'd1;
         S2:      w_cur = 2'd2;
         S3:      w_cur = 2'd3;
         default: w_cur = 2'd0;
      endcase
   end

   // Next-state, pointer and issue-flag logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_issued_nxt = r_issued;
      w_start      = 1'b0;
      case (r_state)
         IDLE: begin
            if (rd_req != 4'b0000) begin
               w_state_nxt  = grant_state(w_pick);
               w_issued_nxt = 1'b0;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         S0, S1, S2, S3: begin
            w_start = rd_req[w_cur] & ~r_issued;
            if (r_issued) begin
               if (rd_done) begin
                  w_state_nxt = IDLE;
                  w_ptr_nxt   = w_cur + 2'd1;
               end else begin
                  w_state_nxt = r_state;
               end
            end else if (rd_req[w_cur]) begin
               w_issued_nxt = 1'b1;
            end else begin
               // requester withdrew before its burst was issued
               w_state_nxt = IDLE;
               w_ptr_nxt   = w_cur + 2'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Address/length mux of the granted channel; zero when idle.
   always_comb begin
      w_addr = 30'd0;
      w_len  = 8'd0;
      case (r_state)
         S0:      begin w_addr = rd_addr0; w_len = rd_len0; end
         S1:      begin w_addr = rd_addr1; w_len = rd_len1; end
         S2:      begin w_addr = rd_addr2; w_len = rd_len2; end
         S3:      begin w_addr = rd_addr3; w_len = rd_len3; end
         default: begin w_addr = 30'd0;    w_len = 8'd0;    end
      endcase
   end

   assign w_grant = {r_state == S3, r_state == S2, r_state == S1, r_state == S0};

   // Arbiter state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_ptr    <= 2'd0;
         r_issued <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_ptr    <= w_ptr_nxt;
         r_issued <= w_issued_nxt;
      end
   end

   // Read-beat capture, routed to whichever channel holds the grant this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data       <= {AXI_WIDTH{1'b0}};
         r_rd_data_valid <= 4'b0000;
      end else begin
         if (axi_rd_data_valid) begin
            r_rd_data <= axi_rd_data;
         end else begin
            r_rd_data <= r_rd_data;
         end
         r_rd_data_valid <= {4{axi_rd_data_valid}} & w_grant;
      end
   end

   assign rd_grant      = w_grant;
   assign axi_rd_start  = w_start;
   assign axi_rd_addr   = w_addr;
   assign axi_rd_len    = w_len;
   assign rd_data       = r_rd_data;
   assign rd_data_valid = r_rd_data_valid;

endmodule

// File: doc/multichannel_rd_arbiter.md
MULTICHANNEL_RD_ARBITER -- requirements
Module: multichannel_rd_arbiter

Interface
REQ-001 SHALL have parameter AXI_WIDTH, default 64, AXI read data width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rd_req  input  4  bit i = read request from channel i.
REQ-005 SHALL have ports rd_addr0..rd_addr3  input  30  read address of channel i.
REQ-006 SHALL have ports rd_len0..rd_len3  input  8  burst length of channel i.
REQ-007 SHALL have port rd_grant  output  4  one-hot grant; bit i = channel i granted.
REQ-008 SHALL have port rd_done  input  1  one-cycle pulse from the AXI read master: burst complete.
REQ-009 SHALL have port axi_rd_start  output  1  read request to the AXI read master.
REQ-010 SHALL have port axi_rd_addr  output  30  read address of the granted channel.
REQ-011 SHALL have port axi_rd_len  output  8  burst length of the granted channel.
REQ-012 SHALL have port axi_rd_data  input  AXI_WIDTH  read beat from the AXI read master.
REQ-013 SHALL have port axi_rd_data_valid  input  1  axi_rd_data is valid this cycle.
REQ-014 SHALL have port rd_data  output  AXI_WIDTH  registered read beat, broadcast to all channels.
REQ-015 SHALL have port rd_data_valid  output  4  bit i = rd_data is valid for channel i.

Function
REQ-016 SHALL implement a one-hot FSM with states IDLE, S0, S1, S2, S3; Si = channel i granted; rd_grant[i] = (state==Si).
REQ-017 SHALL keep a 2-bit priority pointer ptr; the search order is ptr, ptr+1, ptr+2, ptr+3, mod 4.
REQ-018 In IDLE with rd_req!=0, the FSM SHALL enter Sk next cycle, where k = first requesting channel in search order; with rd_req==0 it SHALL stay in IDLE.
REQ-019 SHALL keep an issued flag, cleared on entry to any Si.
REQ-020 In Si, axi_rd_start SHALL be combinational = rd_req[i] & ~issued; issued SHALL set the cycle after axi_rd_start=1, so axi_rd_start is high for exactly one cycle per grant.
REQ-021 axi_rd_addr/axi_rd_len SHALL equal rd_addrI/rd_lenI in Si and 0 in IDLE (combinational mux).
REQ-022 In Si with issued=1, the FSM SHALL hold until rd_done=1, then go to IDLE next cycle and set ptr=(i+1) mod 4.
REQ-023 In Si with issued=0 and rd_req[i]=0 (withdrawn), the FSM SHALL go to IDLE without issuing and set ptr=(i+1) mod 4.
REQ-024 rd_done SHALL be ignored in IDLE and in Si with issued=0.
REQ-025 Every grant SHALL pass through IDLE, giving a minimum one-cycle gap between grants.
REQ-026 rd_data SHALL register axi_rd_data every cycle axi_rd_data_valid=1 (else hold).
REQ-027 rd_data_valid[i] SHALL register axi_rd_data_valid & (state==Si): one-cycle latency, zero in IDLE.
REQ-028 A beat coincident with rd_done SHALL be routed to the channel granted in that cycle.
REQ-029 Changes of rd_req for a non-granted channel during a grant SHALL NOT affect the current grant.

Reset
REQ-030 On rst_n=0, the block SHALL immediately set state=IDLE, ptr=0, issued=0, rd_data=0, rd_data_valid=0, so that rd_grant=0, axi_rd_start=0, axi_rd_addr=0 and axi_rd_len=0.
REQ-031 Reset mid-burst SHALL abandon the grant; beats arriving after reset release while in IDLE SHALL NOT be flagged valid.

Verification
REQ-032 Single request: rd_req=0100, rd_addr2=0x100, rd_len2=15 -> next cycle rd_grant=0100, axi_rd_start=1 for 1 cycle with addr 0x100, len 15; after rd_done, rd_grant=0000 next cycle.
REQ-033 Fairness: rd_req=1111 held after reset -> grant sequence S0,S1,S2,S3,S0, each separated by one IDLE cycle.
REQ-034 Routing: in S1, axi_rd_data_valid=1 with axi_rd_data=0xA5A5_5A5A_0123_4567 -> next cycle rd_data_valid=0010, rd_data=0xA5A5_5A5A_0123_4567.
REQ-035 Withdrawal: S3 entered, rd_req[3] drops before issue -> no axi_rd_start, IDLE next cycle, then rd_req=0011 -> grants S0 (ptr=0).
REQ-036 Reset mid-burst: rst_n low during S2 data phase -> all outputs 0 asynchronously; after release, rd_req=0010 -> S1.
REQ-037 Spurious rd_done: rd_done=1 in IDLE or before issue -> no state or ptr change.
